fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a small prefetch queue.
// Ports: CLK/reset (sync, active-high); rom_req/rom_addr/rom_data ROM
//   read port (data one cycle after request); redirect_en/redirect_target
//   branch redirect; instr/instr_pc/instr_valid/instr_ready head-of-queue
//   handshake to the datapath; DONE sticky halt flag.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2,
   parameter logic [3:0]  HALT_OP  = 4'hF
) (
   input  logic        CLK,
   input  logic        reset,
   output logic        rom_req,
   output logic [15:0] rom_addr,
   input  logic [8:0]  rom_data,
   input  logic        redirect_en,
   input  logic [15:0] redirect_target,
   output logic [8:0]  instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        DONE
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   typedef struct packed {
      logic [8:0]  op;
      logic [15:0] pc;
   } entry_t;

   state_t      state;
   state_t      state_n;

   // Storage is sized for the largest legal DEPTH; only DEPTH slots are used.
   entry_t      q [4];
   entry_t      head_e;
   logic [1:0]  head;
   logic [1:0]  tail;
   logic [2:0]  count;

   logic [15:0] fetch_pc;
   logic        inflight;
   logic [15:0] inflight_pc;

   logic        running;
   logic        vld;
   logic        pop;
   logic        halt_pop;
   logic        redir;
   logic        flush;
   logic        issue;
   logic        wr_en;
   logic [3:0]  occ;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (int'(p) == DEPTH - 1) ? 2'd0 : p + 2'd1;
   endfunction

   // ---------------- control ----------------
   always_comb begin
      running  = (state == RUN) & ~reset;
      head_e   = q[head];
      vld      = running & (count != 3'd0);
      pop      = vld & instr_ready;
      halt_pop = pop & (head_e.op[8:5] == HALT_OP);
      // Halt wins over a redirect in the same cycle.
      redir    = running & redirect_en & ~halt_pop;
      flush    = halt_pop | redir;
      // Slots already committed (queued + in flight) after this pop.
      occ      = {1'b0, count} + {3'b0, inflight} - {3'b0, pop};
      issue    = running & ~redirect_en & ~halt_pop
               & (int'(occ) < DEPTH);
      // Returning data is kept only if nothing flushes this cycle.
      wr_en    = inflight & running & ~flush;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_n;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_n = state;
      unique case (state)
         RUN:    if (halt_pop) state_n = HALTED;
         HALTED: state_n = HALTED;
         default: state_n = RUN;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      rom_req     = issue;
      rom_addr    = fetch_pc;
      instr_valid = vld;
      instr       = head_e.op;
      instr_pc    = head_e.pc;
      DONE        = (state == HALTED);
   end

   // ---------------- fetch pointer / queue bookkeeping ----------------
   always_ff @(posedge CLK) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         head        <= 2'd0;
         tail        <= 2'd0;
         count       <= 3'd0;
         inflight    <= 1'b0;
         inflight_pc <= 16'h0000;
      end else if (flush) begin
         head     <= 2'd0;
         tail     <= 2'd0;
         count    <= 3'd0;
         inflight <= 1'b0;
         if (redir) fetch_pc <= redirect_target;
      end else begin
         if (wr_en) tail <= nxt(tail);
         if (pop)   head <= nxt(head);
         count    <= count + {2'b0, wr_en} - {2'b0, pop};
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 16'd1;
         end
      end
   end

   // ---------------- queue storage ----------------
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         q[tail] <= '{op: rom_data, pc: inflight_pc};
      end
   end

   // The issue rule guarantees a free slot for every returning fetch.
   a_no_overflow : assert property (
      @(posedge CLK) disable iff (reset)
      (wr_en & ~pop) |-> (int'(count) < DEPTH)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against
// a queue-based reference model.
module tb_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [3:0]  HALT_OP  = 4'hF;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        rom_req;
   logic [15:0] rom_addr;
   logic [8:0]  rom_data = 9'h000;
   logic        redirect_en = 1'b0;
   logic [15:0] redirect_target = 16'h0000;
   logic [8:0]  instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        DONE;

   logic        w_rom_req;
   logic [15:0] w_rom_addr;
   logic [8:0]  w_rom_data = 9'h000;
   logic [8:0]  w_instr;
   logic [15:0] w_instr_pc;
   logic        w_instr_valid;
   logic        w_done;

   always #5 CLK = ~CLK;

   fetch_unit #(
      .RESET_PC(RESET_PC), .DEPTH(DEPTH), .HALT_OP(HALT_OP)
   ) u_dut (
      .CLK(CLK), .reset(reset),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data),
      .redirect_en(redirect_en), .redirect_target(redirect_target),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .DONE(DONE)
   );

   fetch_unit #(
      .RESET_PC(16'hFFFE)
   ) u_wrap (
      .CLK(CLK), .reset(reset),
      .rom_req(w_rom_req), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
      .redirect_en(1'b0), .redirect_target(16'h0000),
      .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
      .instr_ready(instr_ready), .DONE(w_done)
   );

   int    checks = 0;
   int    errors = 0;
   string cur_test = "none";

   int         rom_mode  = 0;
   int         halt_addr = -1;
   logic [8:0] salt      = 9'h000;

   // ROM contents: identity or hashed; HALT_OP appears only at halt_addr.
   function automatic logic [8:0] rom_fn(input logic [15:0] a);
      logic [8:0] d;
      if (int'(a) == halt_addr) return 9'h1E0;
      d = (rom_mode == 0) ? a[8:0] : ((a[8:0] * 9'd37) ^ salt ^ a[15:7]);
      if (d[8:5] == HALT_OP) d[5] = ~d[5];
      return d;
   endfunction

   typedef struct {
      logic [8:0]  op;
      logic [15:0] pc;
   } ent_t;

   ent_t        mq[$];
   logic [15:0] m_pc;
   bit          m_pend;
   logic [15:0] m_pend_pc;
   bit          m_halted;

   logic        prev_req = 1'b0;
   logic [15:0] prev_addr = 16'h0000;

   logic        obs_req, obs_valid, obs_done, w_obs_valid;
   logic [15:0] obs_addr, obs_pc, w_obs_pc;

   task automatic model_reset();
      mq.delete();
      m_pc     = RESET_PC;
      m_pend   = 0;
      m_halted = 0;
   endtask

   task automatic hard_reset();
      reset = 1'b1;
      redirect_en = 1'b0;
      instr_ready = 1'b0;
      @(posedge CLK);
      #1;
      model_reset();
      prev_req = 1'b0;
   endtask

   // One clock: apply inputs, compare against the model, advance.
   task automatic step(input logic rst, input logic re,
                       input logic [15:0] tgt, input logic rdy);
      bit   ev, er, pop, hp;
      ent_t e;
      reset = rst;
      redirect_en = re;
      redirect_target = tgt;
      instr_ready = rdy;
      rom_data = prev_req ? rom_fn(prev_addr) : 9'($urandom);
      #1;
      ev  = !rst && !m_halted && mq.size() > 0;
      pop = ev && rdy;
      hp  = pop && (mq[0].op[8:5] == HALT_OP);
      er  = !rst && !m_halted && !re && !hp
            && (mq.size() + int'(m_pend) - int'(pop) < DEPTH);
      checks++;
      if (rom_req !== er) begin
         errors++;
         $display("FAIL %s rom_req got %0b exp %0b", cur_test, rom_req, er);
      end
      checks++;
      if (instr_valid !== ev) begin
         errors++;
         $display("FAIL %s instr_valid got %0b exp %0b",
                  cur_test, instr_valid, ev);
      end
      checks++;
      if (DONE !== m_halted) begin
         errors++;
         $display("FAIL %s DONE got %0b exp %0b", cur_test, DONE, m_halted);
      end
      if (er) begin
         checks++;
         if (rom_addr !== m_pc) begin
            errors++;
            $display("FAIL %s rom_addr got %h exp %h",
                     cur_test, rom_addr, m_pc);
         end
      end
      if (ev) begin
         checks++;
         if (instr !== mq[0].op || instr_pc !== mq[0].pc) begin
            errors++;
            $display("FAIL %s head got %h@%h exp %h@%h", cur_test,
                     instr, instr_pc, mq[0].op, mq[0].pc);
         end
      end
      obs_req = rom_req;   obs_addr = rom_addr;
      obs_valid = instr_valid; obs_pc = instr_pc; obs_done = DONE;
      w_obs_valid = w_instr_valid; w_obs_pc = w_instr_pc;
      prev_req = rom_req;
      prev_addr = rom_addr;
      @(posedge CLK);
      if (rst) begin
         model_reset();
      end else if (!m_halted) begin
         if (pop) void'(mq.pop_front());
         if (m_pend) begin
            e.op = rom_fn(m_pend_pc);
            e.pc = m_pend_pc;
            mq.push_back(e);
         end
         if (hp) begin
            m_halted = 1;
            mq.delete();
            m_pend = 0;
         end else if (re) begin
            mq.delete();
            m_pend = 0;
            m_pc = tgt;
         end else begin
            m_pend = er;
            if (er) begin
               m_pend_pc = m_pc;
               m_pc = m_pc + 16'd1;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cur_test = "reset";
      hard_reset();
      step(1, 0, 0, 1);
      step(1, 1, 16'h1234, 1);
      step(0, 0, 0, 1);
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset first_fetch got %0b@%h exp 1@%h",
                  obs_req, obs_addr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      cur_test = "stream";
      rom_mode = 0;
      step(1, 0, 0, 1);
      for (int k = 1; k <= 10; k++) begin
         step(0, 0, 0, 1);
         if (k >= 3) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_pc !== 16'(k - 3)) begin
               errors++;
               $display("FAIL stream cyc%0d got %0b@%h exp 1@%h",
                        k, obs_valid, obs_pc, 16'(k - 3));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      cur_test = "backpressure";
      step(1, 0, 0, 1);
      for (int k = 1; k <= 6; k++) step(0, 0, 0, 0);
      checks++;
      if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== 16'h0000) begin
         errors++;
         $display("FAIL backpressure hold got req%0b v%0b pc%h exp req0 v1 pc0000",
                  obs_req, obs_valid, obs_pc);
      end
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 1);
         checks++;
         if (obs_valid !== 1'b1 || obs_pc !== 16'(k)) begin
            errors++;
            $display("FAIL backpressure drain%0d got %0b@%h exp 1@%h",
                     k, obs_valid, obs_pc, 16'(k));
         end
      end
   endtask

   task automatic test_redirect();
      bit done_r;
      cur_test = "redirect";
      done_r = 0;
      step(1, 0, 0, 1);
      for (int k = 0; k < 20 && !done_r; k++) begin
         if (mq.size() > 0 && mq[0].pc == 16'h0003) begin
            step(0, 1, 16'h0040, 1);
            done_r = 1;
         end else begin
            step(0, 0, 0, 1);
         end
      end
      checks++;
      if (!done_r) begin
         errors++;
         $display("FAIL redirect pc3_seen got 0 exp 1");
      end
      step(0, 0, 0, 1);
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 16'h0040 || obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect refetch got req%0b@%h v%0b exp req1@0040 v0",
                  obs_req, obs_addr, obs_valid);
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== 16'h0040) begin
         errors++;
         $display("FAIL redirect target got %0b@%h exp 1@0040",
                  obs_valid, obs_pc);
      end
   endtask

   task automatic test_halt();
      cur_test = "halt";
      halt_addr = 2;
      step(1, 0, 0, 1);
      for (int k = 1; k <= 28; k++) begin
         step(0, (k > 5) ? 1'($urandom_range(0, 1)) : 1'b0,
              16'($urandom), 1);
         if (k >= 6) begin
            checks++;
            if (obs_done !== 1'b1 || obs_valid !== 1'b0 || obs_req !== 1'b0) begin
               errors++;
               $display("FAIL halt cyc%0d got done%0b v%0b req%0b exp 1 0 0",
                        k, obs_done, obs_valid, obs_req);
            end
         end
      end
   endtask

   task automatic test_reset_halted();
      cur_test = "reset_halted";
      halt_addr = -1;
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
      checks++;
      if (obs_done !== 1'b0 || obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_halted got done%0b req%0b@%h exp done0 req1@%h",
                  obs_done, obs_req, obs_addr, RESET_PC);
      end
      for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
   endtask

   task automatic test_wrap();
      logic [15:0] exp_pc;
      cur_test = "wrap";
      step(1, 0, 0, 1);
      for (int k = 1; k <= 6; k++) begin
         step(0, 0, 0, 1);
         if (k >= 3) begin
            exp_pc = 16'hFFFE + 16'(k - 3);
            checks++;
            if (w_obs_valid !== 1'b1 || w_obs_pc !== exp_pc) begin
               errors++;
               $display("FAIL wrap cyc%0d got %0b@%h exp 1@%h",
                        k, w_obs_valid, w_obs_pc, exp_pc);
            end
         end
      end
   endtask

   task automatic test_random();
      logic        rst, re, rdy;
      logic [15:0] tgt;
      cur_test = "random";
      rom_mode = 1;
      salt = 9'($urandom);
      halt_addr = 16'h0023;
      step(1, 0, 0, 1);
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         re  = ($urandom_range(0, 19) == 0);
         tgt = ($urandom_range(0, 3) == 0)
               ? 16'hFFF8 + 16'($urandom_range(0, 7))
               : 16'($urandom_range(0, 63));
         rdy = ($urandom_range(0, 9) < 7);
         step(rst, re, tgt, rdy);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_reset_halted();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
